// File: rtl/my_axis_if.sv
// AXI4-Stream style bundle with a configurable data width and byte-granular tkeep.
// Handshake: a transfer happens on every rising clk edge where tvalid && tready;
// once tvalid is high the master holds tdata/tkeep/tlast stable until that transfer.
interface my_axis_if #(
  parameter int DATA_W = 8
);
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_byte_unpack.sv
// Unpacks wide stream beats into kept bytes, lane 0 first, skipping unkept lanes.
// Optional AXIS_BYTE_UNPACK_SKID_EN adds a second beat register for bubble-free streaming.
module axis_byte_unpack #(
  parameter int IN_W = 128
) (
  input  logic       clk,
  input  logic       rst,
  my_axis_if.slave   s_axis,
  my_axis_if.master  m_axis,
  output logic       null_beat,
  output logic       busy,
  output logic       dbg_state_o
);
  localparam int NB    = IN_W / 8;
  localparam int IDX_W = $clog2(NB);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   work_data_q, work_data_d;
  logic [NB-1:0]     work_keep_q, work_keep_d;
  logic              work_last_q, work_last_d;
  logic              null_q, null_d;
`ifdef AXIS_BYTE_UNPACK_SKID_EN
  logic [IN_W-1:0]   hold_data_q, hold_data_d;
  logic [NB-1:0]     hold_keep_q, hold_keep_d;
  logic              hold_last_q, hold_last_d;
  logic              hold_valid_q, hold_valid_d;
  logic              last_hs;
`endif

  logic [IDX_W-1:0]  lane;
  logic [NB-1:0]     lane_oh;
  logic [NB-1:0]     keep_rest;
  logic              in_accept, in_null, out_hs;

  // Descending scan so the lowest kept lane is the final assignment.
  always_comb begin
    lane    = '0;
    lane_oh = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (work_keep_q[i]) begin
        lane    = IDX_W'(i);
        lane_oh = NB'(1) << i;
      end
    end
    keep_rest = work_keep_q & ~lane_oh;
  end

`ifdef AXIS_BYTE_UNPACK_SKID_EN
  assign s_axis.tready = !rst && !hold_valid_q;
  assign busy          = (state_q == SHIFT) || hold_valid_q;
  assign last_hs       = out_hs && (keep_rest == '0);
`else
  assign s_axis.tready = !rst && (state_q == IDLE);
  assign busy          = (state_q == SHIFT);
`endif

  assign in_accept     = s_axis.tvalid && s_axis.tready;
  assign in_null       = (s_axis.tkeep == '0);
  assign out_hs        = m_axis.tvalid && m_axis.tready;

  assign m_axis.tvalid = (state_q == SHIFT);
  assign m_axis.tdata  = (state_q == SHIFT) ? work_data_q[{lane, 3'b000} +: 8] : 8'h00;
  assign m_axis.tkeep  = '1;
  assign m_axis.tlast  = (state_q == SHIFT) && work_last_q && (keep_rest == '0);
  assign null_beat     = null_q;
  assign dbg_state_o   = (state_q == SHIFT);

  always_comb begin
    state_d     = state_q;
    work_data_d = work_data_q;
    work_keep_d = work_keep_q;
    work_last_d = work_last_q;
    null_d      = in_accept && in_null;
`ifdef AXIS_BYTE_UNPACK_SKID_EN
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_accept && !in_null) begin
          work_data_d = s_axis.tdata;
          work_keep_d = s_axis.tkeep;
          work_last_d = s_axis.tlast;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (out_hs) begin
          work_keep_d = keep_rest;
          if (keep_rest == '0) begin
`ifdef AXIS_BYTE_UNPACK_SKID_EN
            if (hold_valid_q) begin
              work_data_d  = hold_data_q;
              work_keep_d  = hold_keep_q;
              work_last_d  = hold_last_q;
              hold_valid_d = 1'b0;
            end else if (in_accept && !in_null) begin
              work_data_d = s_axis.tdata;
              work_keep_d = s_axis.tkeep;
              work_last_d = s_axis.tlast;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef AXIS_BYTE_UNPACK_SKID_EN
        // A beat arriving mid-stream parks here unless the working register frees up this cycle.
        if (in_accept && !in_null && !last_hs) begin
          hold_data_d  = s_axis.tdata;
          hold_keep_d  = s_axis.tkeep;
          hold_last_d  = s_axis.tlast;
          hold_valid_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_data_q <= '0;
      work_keep_q <= '0;
      work_last_q <= 1'b0;
      null_q      <= 1'b0;
`ifdef AXIS_BYTE_UNPACK_SKID_EN
      hold_data_q  <= '0;
      hold_keep_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      work_data_q <= work_data_d;
      work_keep_q <= work_keep_d;
      work_last_q <= work_last_d;
      null_q      <= null_d;
`ifdef AXIS_BYTE_UNPACK_SKID_EN
      hold_data_q  <= hold_data_d;
      hold_keep_q  <= hold_keep_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
`endif
    end
  end
endmodule

// File: tb/tb_axis_byte_unpack.sv
// Self-checking bench for axis_byte_unpack: directed timing cases plus random beats
// checked against a byte-queue reference model.
module tb_axis_byte_unpack;
  localparam int IN_W = 128;
  localparam int NB   = IN_W / 8;
`ifdef AXIS_BYTE_UNPACK_SKID_EN
  localparam int B2B_GAP = 1;
`else
  localparam int B2B_GAP = 2;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  my_axis_if #(.DATA_W(IN_W)) s_if ();
  my_axis_if #(.DATA_W(8))    m_if ();
  logic null_beat, busy, dbg_state;

  axis_byte_unpack #(.IN_W(IN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .null_beat   (null_beat),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: {tlast, byte} per expected output transfer
  logic [8:0] exp_q[$];
  int         hs_q[$];
  int         null_exp  = 0;
  int         null_seen = 0;
  int         acc_cyc   = 0;

  function automatic void model_push(input logic [IN_W-1:0] d, input logic [NB-1:0] k, input logic l);
    int last_k = -1;
    for (int i = 0; i < NB; i++) if (k[i]) last_k = i;
    if (last_k < 0) null_exp++;
    else
      for (int i = 0; i <= last_k; i++)
        if (k[i]) exp_q.push_back({l && (i == last_k), d[8*i +: 8]});
  endfunction

  function automatic logic [IN_W-1:0] rand_data();
    logic [IN_W-1:0] d;
    for (int i = 0; i < IN_W / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // m_axis.tready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  int rdy_mode = 0;
  initial begin
    int ph = 0;
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       m_if.tready = (ph % 4 == 0) || (ph % 4 == 3);
        2:       m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = 1'b1;
      endcase
      ph++;
    end
  end

  // output monitor
  initial begin
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", m_if.tvalid, 1);
          check("stall_data", m_if.tdata, prev_data);
          check("stall_last", m_if.tlast, prev_last);
        end
        check("valid_vs_model", m_if.tvalid, exp_q.size() != 0);
        check("busy_vs_model", busy, exp_q.size() != 0);
        if (m_if.tvalid) check("tkeep", m_if.tkeep, 1);
        if (m_if.tvalid && m_if.tready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("byte", {m_if.tlast, m_if.tdata}, e);
          hs_q.push_back(cyc + 1);
        end
        if (null_beat) null_seen++;
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_data  = m_if.tdata;
        prev_last  = m_if.tlast;
      end
    end
  end

  // driver tasks (entered just after a rising edge)
  task automatic send_beat(input logic [IN_W-1:0] d, input logic [NB-1:0] k, input logic l);
    logic ok;
    logic done = 1'b0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      ok = s_if.tready;
      @(posedge clk);
      #1;
      if (ok) begin
        acc_cyc = cyc;
        model_push(d, k, l);
        done = 1'b1;
      end
    end
    s_if.tvalid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
    idle(2);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] full;
    int base, a, ns;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    full = 128'h0F0E0D0C0B0A09080706050403020100;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tready", s_if.tready, 0);
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tlast", m_if.tlast, 0);
    check("rst_tdata", m_if.tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_null", null_beat, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", s_if.tready, 1);
    @(posedge clk); #1;

    // full beat: 16 consecutive bytes starting the cycle after acceptance
    base = hs_q.size();
    send_beat(full, 16'hFFFF, 1'b1);
    a = acc_cyc;
    wait_drain();
    check("full_count", hs_q.size() - base, 16);
    for (int i = 0; i < 16; i++) check("full_cycle", hs_q[base + i], a + 1 + i);

    // sparse keep, with and without tlast
    base = hs_q.size();
    send_beat(rand_data(), 16'h8005, 1'b1);
    wait_drain();
    check("sparse_count_last", hs_q.size() - base, 3);
    base = hs_q.size();
    send_beat(rand_data(), 16'h8005, 1'b0);
    wait_drain();
    check("sparse_count_nolast", hs_q.size() - base, 3);

    // null beat
    ns = null_seen;
    send_beat(rand_data(), 16'h0000, 1'b1);
    @(negedge clk);
    check("null_pulse", null_beat, 1);
    check("null_state_idle", dbg_state, 0);
    check("null_no_valid", m_if.tvalid, 0);
    @(negedge clk);
    check("null_one_cycle", null_beat, 0);
    check("null_seen", null_seen - ns, 1);
    idle(1);

    // backpressure 1,0,0,1
    rdy_mode = 1;
    idle(2);
    base = hs_q.size();
    send_beat(full, 16'hFFFF, 1'b1);
    wait_drain();
    check("bp_count", hs_q.size() - base, 16);
    rdy_mode = 0;
    idle(3);

    // back-to-back full beats
    base = hs_q.size();
    send_beat(rand_data(), 16'hFFFF, 1'b0);
    a = acc_cyc;
    send_beat(rand_data(), 16'hFFFF, 1'b1);
    wait_drain();
    check("b2b_count", hs_q.size() - base, 32);
    check("b2b_first", hs_q[base], a + 1);
    for (int i = 0; i < 31; i++)
      check("b2b_gap", hs_q[base + i + 1] - hs_q[base + i], (i == 15) ? B2B_GAP : 1);

    // reset after the 5th byte handshake
    base = hs_q.size();
    send_beat(full, 16'hFFFF, 1'b1);
    for (int t = 0; t < 100 && (hs_q.size() - base) < 5; t++) idle(1);
    check("mid_rst_reached5", hs_q.size() - base, 5);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tvalid", m_if.tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tready", s_if.tready, 0);
    check("mid_rst_tdata", m_if.tdata, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tready_after", s_if.tready, 1);
    @(posedge clk); #1;
    base = hs_q.size();
    send_beat(rand_data(), 16'hFFFF, 1'b1);
    a = acc_cyc;
    wait_drain();
    check("restart_count", hs_q.size() - base, 16);
    check("restart_first", hs_q[base], a + 1);

    // random beats: random ready for half, always-ready for the rest
    for (int n = 0; n < 80; n++) begin
      logic [NB-1:0] k;
      rdy_mode = (n < 40) ? 2 : 0;
      case ($urandom_range(0, 3))
        0:       k = '0;
        1:       k = '1;
        2:       k = NB'($urandom);
        default: k = NB'(1) << $urandom_range(0, NB - 1);
      endcase
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send_beat(rand_data(), k, 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    wait_drain();
    check("null_total", null_seen, null_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_byte_unpack.md
AXIS_BYTE_UNPACK -- requirements
Module: axis_byte_unpack

Interface
REQ-001 SHALL have parameter IN_W, default 128, meaning the input stream data width in bits (multiple of 8, 16..256).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the reset: synchronous and active-high.
REQ-004 SHALL have port s_axis, my_axis_if.slave, DATA_W=IN_W, the block input (AES block side).
REQ-005 SHALL have port m_axis, my_axis_if.master, DATA_W=8, the byte output (UART TX side).
REQ-006 SHALL have port null_beat, output, 1 bit, a one-cycle pulse when an all-zero-tkeep beat is discarded.
REQ-007 SHALL have port busy, output, 1 bit, high while any accepted beat still has bytes pending.

Function
REQ-008 SHALL accept an input beat on s_axis.tvalid && s_axis.tready, registering tdata, tkeep and tlast.
REQ-009 SHALL emit kept bytes in ascending lane order: lane 0 (tdata[7:0]) first and lane IN_W/8-1 last.
REQ-010 SHALL skip lanes with tkeep=0, with no output cycle spent on them.
REQ-011 SHALL drive m_axis.tkeep=1 on every output byte.
REQ-012 SHALL assert m_axis.tlast only on the final kept byte of a beat whose registered tlast=1.
REQ-013 SHALL discard a beat with tkeep all zero, emitting no byte, pulsing null_beat the cycle after acceptance, and dropping its tlast.
REQ-014 SHALL run a two-state FSM: IDLE has no pending bytes; SHIFT has m_axis.tvalid=1.
REQ-015 SHALL transition IDLE->SHIFT on acceptance of a beat with a non-zero tkeep.
REQ-016 SHALL transition SHIFT->IDLE on the handshake of the last kept byte, unless a further beat is held (REQ-024).
REQ-017 SHALL have a latency of one cycle: a beat accepted in cycle N presents its first byte in cycle N+1.
REQ-018 SHALL advance to the next kept byte only on m_axis.tvalid && m_axis.tready, selecting the lowest remaining kept lane with a priority encoder.
REQ-019 SHALL hold m_axis.tdata and m_axis.tlast stable while m_axis.tvalid=1 and m_axis.tready=0.
REQ-020 SHALL never deassert m_axis.tvalid before its handshake.
REQ-021 SHALL make s_axis.tready independent of s_axis.tvalid, with no combinational path from m_axis.tready to s_axis.tready.
REQ-022 SHALL drive busy=1 exactly when the FSM is in SHIFT or a held beat exists.

Reset
REQ-023 SHALL, when rst=1, put the FSM in IDLE at the next edge; m_axis.tvalid=0, m_axis.tlast=0, m_axis.tdata=0, null_beat=0, busy=0; any partially emitted or held beat is discarded; s_axis.tready=0 during rst and 1 in the first cycle after.

Configuration
REQ-024 SHALL provide macro AXIS_BYTE_UNPACK_SKID_EN.
- Defined: a second IN_W holding register is added; s_axis.tready = !hold_valid; a beat accepted during SHIFT is loaded into the hold register, then into the working register on the last-byte handshake; the first byte of the held beat is valid the next cycle, so the stream has no bubble.
- Undefined: s_axis.tready=1 only in IDLE; one idle output cycle follows each beat; there is no hold register.

Verification
REQ-025 Full beat: tdata=0x0F0E..0100, tkeep=0xFFFF, tlast=1, m_axis.tready=1 -> bytes 0x00..0x0F in 16 consecutive cycles starting at N+1; tlast only on 0x0F.
REQ-026 Sparse keep: tkeep=0x8005, tlast=1 -> exactly 3 bytes (lanes 0, 2, 15), tlast on lane 15; tlast=0 variant -> no tlast.
REQ-027 Backpressure: m_axis.tready toggling 1,0,0,1 per cycle -> data held stable while stalled; all 16 bytes delivered in order, none duplicated.
REQ-028 Null beat: tkeep=0x0000, tlast=1 -> no m_axis.tvalid; null_beat high for one cycle at N+1; FSM stays IDLE.
REQ-029 Back-to-back: two full beats, m_axis.tready=1 -> with SKID_EN 32 consecutive bytes; without it, exactly one idle cycle between byte 15 and byte 16.
REQ-030 Reset mid-operation: rst=1 after the 5th byte handshake -> m_axis.tvalid=0 next cycle; a fresh beat then restarts output from its lane 0.
